// File: rtl/multiplier.sv
// multiplier: sequential unsigned shift-and-add multiplier, one multiplier bit per clock
module multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last;
  assign last     = cnt == CW'(WIDTH - 1);
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  always_comb
    state_next = (state == IDLE && start) ? RUN :
                 (state == RUN && last)   ? IDLE : state;
  always_comb
    busy = state == RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      y      <= '0;
      done   <= 1'b0;
    end else if (state == IDLE) begin
      done <= 1'b0;
      if (start) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
    end else begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      done   <= last;
      if (last) y <= acc_next;
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: table-driven vectors plus hand sequences, scoreboard queue checked on done
module tb_multiplier;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst, start;
  logic [W-1:0] a, b;
  logic [2*W-1:0] y;
  logic busy, done;
  always #5 clk = ~clk;
  multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .y(y), .busy(busy), .done(done)
  );
  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] y;
  } vec_t;
  vec_t tbl[6];
  int cmp = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [2*W-1:0] q[$];
  logic [2*W-1:0] last_exp = '0;
  logic [2*W-1:0] e_pop;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // scoreboard: every done pulse must match the oldest outstanding expected product
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("done_busy_overlap", {31'd0, busy}, 32'd0);
      if (q.size() == 0) begin
        cmp++;
        bad++;
        $display("FAIL unexpected_done: y=%0d with no expected result", y);
      end else begin
        e_pop = q.pop_front();
        check("product", {24'd0, y}, {24'd0, e_pop});
        last_exp = e_pop;
      end
    end
  end
  task automatic wait_done(input string name, input int exp_lat);
    int k = 0;
    @(negedge clk);
    k++;
    while (done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      cmp++;
      bad++;
      $display("FAIL %s: timeout after %0d cycles, required done", name, k);
    end else check(name, k, exp_lat);
  endtask
  task automatic run_op(input vec_t v);
    int d0;
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    q.push_back(v.y);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_capture", {31'd0, busy}, 32'd1);
    check("y_hold_in_run", {24'd0, y}, {24'd0, last_exp});
    a = ~v.a;
    b = ~v.b;
    wait_done("latency", 4);
    @(negedge clk);
    check("done_single_pulse", done_cnt - d0, 1);
    check("done_low_after", {31'd0, done}, 32'd0);
  endtask
  initial begin
    int d0;
    tbl[0] = '{4'd4,  4'd2,  8'h08};
    tbl[1] = '{4'd15, 4'd15, 8'hE1};
    tbl[2] = '{4'd15, 4'd1,  8'h0F};
    tbl[3] = '{4'd1,  4'd15, 8'h0F};
    tbl[4] = '{4'd0,  4'd9,  8'h00};
    tbl[5] = '{4'd7,  4'd0,  8'h00};
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_y", {24'd0, y}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run_op(tbl[i]);
    // start during RUN must be ignored
    @(negedge clk);
    a = 4'd3;
    b = 4'd5;
    start = 1'b1;
    q.push_back(8'h0F);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 4'd6;
    wait_done("busy_prot_latency", 1);
    repeat (8) @(negedge clk);
    check("busy_prot_one_done", done_cnt - d0, 1);
    // start held high: second capture on the done cycle
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    q.push_back(8'h2A);
    wait_done("b2b_first_latency", 5);
    a = 4'd2;
    b = 4'd3;
    q.push_back(8'h06);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_idle", {31'd0, busy}, 32'd1);
    check("b2b_y_hold", {24'd0, y}, 32'h2A);
    wait_done("b2b_second_latency", 4);
    @(negedge clk);
    // reset mid-operation aborts without a done pulse
    a = 4'd12;
    b = 4'd11;
    start = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_y", {24'd0, y}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    last_exp = '0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    run_op('{4'd5, 4'd5, 8'h19});
    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Sequential unsigned shift-and-add multiplier: operands `a` × `b`, product `y`.
- Processes one multiplier bit per clock; start/busy/done handshake.
- Datapath helper block; product register holds its last result until the next completion.
- Default configuration is 4×4 → 8-bit (e.g. 4 × 2 = 8).

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH; legal range 2..16.

Ports:
- clk    input   1          rising-edge clock
- rst    input   1          synchronous reset, active-high
- start  input   1          request a multiply; sampled on rising edge of clk
- a      input   WIDTH      multiplicand, unsigned
- b      input   WIDTH      multiplier, unsigned
- y      output  2*WIDTH    product register, unsigned
- busy   output  1          high while an operation is in progress
- done   output  1          one-cycle pulse: y has just been updated

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over everything else.
  - On reset: state=IDLE, y=0, busy=0, done=0; internal accumulator, shift registers and bit counter cleared.
- States:
  - IDLE: busy=0. On an edge with start=1, capture a into the multiplicand register (zero-extended to 2*WIDTH) and b into the multiplier shift register. Clear accumulator and counter, then go to RUN.
  - RUN: busy=1. Each edge:
    - if multiplier LSB=1, accumulator += multiplicand;
    - multiplicand shifts left 1, multiplier shifts right 1, counter increments.
    - After the WIDTH-th RUN edge, load y with the final accumulator, assert done for one cycle, return to IDLE.
- Latency:
  - Capture edge E0; result written at edge E0+WIDTH (4 edges by default).
  - done is high for exactly the one cycle following that edge.
  - busy is high from after E0 until that edge; busy and done are never high together.
- Inputs and handshake:
  - a and b are sampled only at the capture edge. Changes during RUN have no effect.
  - start is ignored while busy=1 (no queuing, no restart).
  - start=1 while done=1 (state is IDLE) is accepted: back-to-back operation with no dead cycle.
  - start held high continuously runs repeated operations; each takes WIDTH+1 cycles including the capture cycle.
- Output holding:
  - y changes only at completion or on reset.
  - Between completions, y holds the previous product, also during RUN.
- Arithmetic:
  - Unsigned; full 2*WIDTH-bit product, never overflows.
  - Max case (2^WIDTH−1)^2 fits; 15×15=225.
  - Operand zero still takes the full WIDTH cycles; no early termination.
- Reset mid-operation: aborts immediately. No done pulse. y becomes 0. Next start begins a fresh operation.
- done and busy are registered outputs with no combinational path from inputs.

Test Plan:
- Reset: rst=1 for 2 cycles → y=0, busy=0, done=0. Then a=4'b0100, b=4'b0010, one-cycle start → busy high for 4 cycles, done pulses once, y=8'h08.
- Max operands: a=15, b=15 → y=8'hE1 (225) after 4 cycles. Then a=15, b=1 → y=8'h0F. Then a=1, b=15 → y=8'h0F.
- Zero: a=0, b=9 → y=0; a=7, b=0 → y=0. Each completes in exactly 4 cycles with a single done pulse.
- Busy protection: start a=3, b=5. Two cycles later pulse start with a=9, b=9 and also change a/b → result y=15 (8'h0F); no second done pulse follows.
- Back-to-back: start held high with a=6, b=7 then a=2, b=3 presented at the done cycle → y=42 (8'h2A), then y=6, with no idle cycle between.
- Reset mid-op: start a=12, b=11, assert rst two cycles later → y=0, busy=0, no done. Then a=5, b=5 → y=25 (8'h19).
